voice_sample_scheduler: RTL and testbench

VOICE_SAMPLE_SCHEDULER -- requirements
Module: voice_sample_scheduler

---
 rtl/synth_pkg.sv | 13 +
 rtl/sample_period_timer.sv | 46 ++++
 rtl/voice_sample_scheduler.sv | 121 ++++++++++++
 tb/tb_voice_sample_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the voice sample scheduler: FSM state encoding and
// the sample-period divisor used out of reset.
package synth_pkg;

  localparam logic [27:0] DEFAULT_DIVISOR = 28'd1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_SERVE  = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/sample_period_timer.sv
// Programmable sample-period counter producing the per-period tick strobe and
// a square-wave sample clock.
module sample_period_timer #(
  parameter int unsigned          DIV_WIDTH       = 28,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIVISOR = DIV_WIDTH'(synth_pkg::DEFAULT_DIVISOR)
) (
  input  logic                 clock_in,
  input  logic                 Reset,
  input  logic [DIV_WIDTH-1:0] divisor_in,
  input  logic                 divisor_load,
  output logic                 sample_tick,
  output logic                 sample_clk
);

  localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(2);

  logic [DIV_WIDTH-1:0] count_q, count_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 at_end;

  always_comb begin
    at_end  = (count_q == (div_q - DIV_WIDTH'(1)));
    div_d   = div_q;
    count_d = at_end ? '0 : count_q + DIV_WIDTH'(1);
    // A fresh divisor restarts the period from zero; divisors below 2 cannot
    // form a period with both a low and a high half.
    if (divisor_load) begin
      div_d   = (divisor_in < MIN_DIV) ? MIN_DIV : divisor_in;
      count_d = '0;
    end
  end

  always_ff @(posedge clock_in) begin
    if (Reset) begin
      count_q <= '0;
      div_q   <= DEFAULT_DIVISOR;
    end else begin
      count_q <= count_d;
      div_q   <= div_d;
    end
  end

  assign sample_tick = at_end & ~divisor_load & ~Reset;
  assign sample_clk  = (count_q >= (div_q >> 1));

endmodule

// File: rtl/voice_sample_scheduler.sv
// Per-sample voice scheduler: latches active voices on each sample tick and
// grants them one at a time, lowest index first, to the shared voice engine.
module voice_sample_scheduler #(
  parameter int unsigned          NUM_VOICES      = 4,
  parameter int unsigned          DIV_WIDTH       = 28,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIVISOR = DIV_WIDTH'(synth_pkg::DEFAULT_DIVISOR),
  localparam int unsigned         IDX_W           = $clog2(NUM_VOICES)
) (
  input  logic                  clock_in,
  input  logic                  Reset,
  input  logic [DIV_WIDTH-1:0]  divisor_in,
  input  logic                  divisor_load,
  input  logic [NUM_VOICES-1:0] voice_req,
  input  logic                  voice_done,
  output logic                  sample_tick,
  output logic                  sample_clk,
  output logic [NUM_VOICES-1:0] voice_grant,
  output logic [IDX_W-1:0]      voice_idx,
  output logic                  frame_done,
  output logic                  overrun
);

  import synth_pkg::*;

  fsm_state_t            state_q, state_d;
  logic [NUM_VOICES-1:0] pending_q, pending_d;
  logic [NUM_VOICES-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      low_idx;
  logic                  frame_done_q, frame_done_d;
  logic                  overrun_q, overrun_d;

  sample_period_timer #(
    .DIV_WIDTH       (DIV_WIDTH),
    .DEFAULT_DIVISOR (DEFAULT_DIVISOR)
  ) u_timer (
    .clock_in     (clock_in),
    .Reset        (Reset),
    .divisor_in   (divisor_in),
    .divisor_load (divisor_load),
    .sample_tick  (sample_tick),
    .sample_clk   (sample_clk)
  );

  // Descending scan so the lowest pending index is the last one written.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    grant_d      = grant_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    if (sample_tick && (state_q != ST_IDLE)) overrun_d = 1'b1;
    if (divisor_load) overrun_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          pending_d = voice_req;
          if (voice_req == '0) frame_done_d = 1'b1;
          else                 state_d      = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (sample_tick) begin
          pending_d = voice_req;
        end else if (pending_q == '0) begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          grant_d = NUM_VOICES'(1) << low_idx;
          idx_d   = low_idx;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (voice_done) begin
          grant_d   = '0;
          idx_d     = '0;
          pending_d = pending_q & ~grant_q;
          state_d   = ST_SELECT;
        end
        // A voice finishing on the tick stays pending only if it is requested
        // again, which the fresh voice_req snapshot already expresses.
        if (sample_tick) pending_d = voice_req;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      grant_q      <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      grant_q      <= grant_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign voice_grant = grant_q;
  assign voice_idx   = idx_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_voice_sample_scheduler.sv
// Self-checking bench for voice_sample_scheduler: directed scenarios plus a
// randomized run, all compared against a behavioural frame/grant model.
module tb_voice_sample_scheduler;

  localparam int NV      = 4;
  localparam int DW      = 28;
  localparam int DEF_DIV = 1024;

  logic          clock_in = 1'b0;
  logic          Reset = 1'b1;
  logic [DW-1:0] divisor_in = '0;
  logic          divisor_load = 1'b0;
  logic [NV-1:0] voice_req = '0;
  logic          voice_done = 1'b0;
  logic          sample_tick, sample_clk, frame_done, overrun;
  logic [NV-1:0] voice_grant;
  logic [1:0]    voice_idx;

  voice_sample_scheduler #(
    .NUM_VOICES      (NV),
    .DIV_WIDTH       (DW),
    .DEFAULT_DIVISOR (DW'(DEF_DIV))
  ) dut (
    .clock_in     (clock_in),
    .Reset        (Reset),
    .divisor_in   (divisor_in),
    .divisor_load (divisor_load),
    .voice_req    (voice_req),
    .voice_done   (voice_done),
    .sample_tick  (sample_tick),
    .sample_clk   (sample_clk),
    .voice_grant  (voice_grant),
    .voice_idx    (voice_idx),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  always #5 clock_in = ~clock_in;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;

  // Reference model: period from arithmetic on elapsed cycles, frame as a
  // pending voice set with "currently served voice" and "choosing next" flags.
  int            m_div;
  longint        m_start;
  bit [NV-1:0]   m_pending;
  int            m_cur;
  bit            m_choosing;
  bit            m_fd;
  bit            m_ov;
  int            g_age = 0;

  // {tick, clk, frame_done, overrun, idx[1:0], grant[3:0]}
  logic [9:0] e_vec, a_vec;

  function automatic int lowest(input bit [NV-1:0] m);
    for (int i = 0; i < NV; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic bit want_done(input int k);
    return (m_cur >= 0) && (g_age == k);
  endfunction

  task automatic model_reset();
    m_div = DEF_DIV; m_start = cyc + 1; m_pending = '0;
    m_cur = -1; m_choosing = 1'b0; m_fd = 1'b0; m_ov = 1'b0;
  endtask

  task automatic cycle(input bit rst, input bit [NV-1:0] req, input bit done,
                       input bit load, input int din);
    longint      cnt;
    bit          tick, busy;
    int          n_cur;
    bit          n_choosing, n_fd;
    bit [NV-1:0] n_pend;
    Reset = rst; voice_req = req; voice_done = done;
    divisor_load = load; divisor_in = DW'(din);
    @(negedge clock_in);
    cnt  = (cyc - m_start) % m_div;
    tick = !rst && !load && (cnt == longint'(m_div - 1));
    e_vec = {tick, cnt >= longint'(m_div / 2), m_fd, m_ov,
             (m_cur < 0) ? 2'd0 : 2'(m_cur), (m_cur < 0) ? 4'd0 : 4'(1 << m_cur)};
    a_vec = {sample_tick, sample_clk, frame_done, overrun, voice_idx, voice_grant};
    g_age = (m_cur >= 0) ? g_age + 1 : 0;
    if (rst) begin
      model_reset();
    end else begin
      busy = m_choosing || (m_cur >= 0);
      n_cur = m_cur; n_choosing = m_choosing; n_fd = 1'b0; n_pend = m_pending;
      if (tick && busy) m_ov = 1'b1;
      if (load) begin
        m_div = (din < 2) ? 2 : din; m_start = cyc + 1; m_ov = 1'b0;
      end
      if (m_cur >= 0) begin
        if (done) begin n_pend[m_cur] = 1'b0; n_cur = -1; n_choosing = 1'b1; end
        if (tick) n_pend = req;
      end else if (m_choosing) begin
        if (tick) n_pend = req;
        else if (m_pending == '0) begin n_fd = 1'b1; n_choosing = 1'b0; end
        else begin n_cur = lowest(m_pending); n_choosing = 1'b0; end
      end else if (tick) begin
        n_pend = req;
        if (req == '0) n_fd = 1'b1; else n_choosing = 1'b1;
      end
      m_cur = n_cur; m_choosing = n_choosing; m_fd = n_fd; m_pending = n_pend;
    end
    @(posedge clock_in); #1;
    cyc++;
  endtask

  task automatic test_reset();
    cycle(1'b1, '0, 1'b0, 1'b0, 0);
    cycle(1'b1, '0, 1'b0, 1'b0, 0);
    cycle(1'b0, '0, 1'b0, 1'b0, 0);
    checks++;
    if (a_vec !== 10'b0) begin
      errors++; $display("FAIL reset_values got=%b want=%b", a_vec, 10'b0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0, 0);
      checks++;
      if (a_vec !== e_vec) begin
        errors++; $display("FAIL reset_idle cyc=%0d got=%b want=%b", cyc, a_vec, e_vec);
      end
    end
  endtask

  task automatic test_idle_ticks();
    int ticks = 0, fds = 0, fd_after_tick = 0, clk_high = 0;
    bit prev_tick = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b1, 8);
    for (int i = 1; i <= 33; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0, 0);
      checks++;
      if (a_vec !== e_vec) begin
        errors++; $display("FAIL idle_ticks cyc=%0d got=%b want=%b", cyc, a_vec, e_vec);
      end
      ticks += a_vec[9]; fds += a_vec[7];
      if (i <= 32) clk_high += a_vec[8];
      if (a_vec[7] && prev_tick) fd_after_tick++;
      prev_tick = a_vec[9];
    end
    checks++;
    if (ticks != 4) begin errors++; $display("FAIL idle_tick_count got=%0d want=4", ticks); end
    checks++;
    if (clk_high != 16) begin errors++; $display("FAIL idle_clk_high got=%0d want=16", clk_high); end
    checks++;
    if (fds != 4 || fd_after_tick != 4) begin
      errors++; $display("FAIL idle_frame_done got=%0d/%0d want=4/4", fds, fd_after_tick);
    end
  endtask

  task automatic test_ordered_frame();
    int order[$];
    int fds = 0, ov_seen = 0, handovers = 0;
    logic [3:0] prev_g = '0;
    cycle(1'b0, '0, 1'b0, 1'b1, 64);
    for (int i = 0; i < 120; i++) begin
      cycle(1'b0, 4'b1011, want_done(3), 1'b0, 0);
      checks++;
      if (a_vec !== e_vec) begin
        errors++; $display("FAIL ordered_frame cyc=%0d got=%b want=%b", cyc, a_vec, e_vec);
      end
      if (prev_g == 4'b0 && a_vec[3:0] != 4'b0) order.push_back(int'(a_vec[5:4]));
      if (prev_g != 4'b0 && a_vec[3:0] != 4'b0 && a_vec[3:0] != prev_g) handovers++;
      prev_g = a_vec[3:0];
      fds += a_vec[7]; ov_seen += a_vec[6];
    end
    checks++;
    if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 3) begin
      errors++; $display("FAIL ordered_grant_seq got=%p want='{0,1,3}", order);
    end
    checks++;
    if (fds != 1) begin errors++; $display("FAIL ordered_frame_done got=%0d want=1", fds); end
    checks++;
    if (ov_seen != 0 || handovers != 0) begin
      errors++; $display("FAIL ordered_no_overrun got=%0d/%0d want=0/0", ov_seen, handovers);
    end
  endtask

  task automatic test_overrun();
    int order[$];
    logic [3:0] prev_g = '0;
    logic [3:0] g_at_ov = '0;
    bit ov_found = 1'b0;
    cycle(1'b1, '0, 1'b0, 1'b0, 0);
    cycle(1'b0, '0, 1'b0, 1'b1, 16);
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 4'b1111, want_done(5), 1'b0, 0);
      checks++;
      if (a_vec !== e_vec) begin
        errors++; $display("FAIL overrun_run cyc=%0d got=%b want=%b", cyc, a_vec, e_vec);
      end
      if (prev_g == 4'b0 && a_vec[3:0] != 4'b0) order.push_back(int'(a_vec[5:4]));
      prev_g = a_vec[3:0];
      if (a_vec[6] && !ov_found) begin ov_found = 1'b1; g_at_ov = a_vec[3:0]; end
    end
    checks++;
    if (!ov_found || g_at_ov !== 4'b0100) begin
      errors++; $display("FAIL overrun_during_v2 got=%0b grant=%b want=1 grant=0100", ov_found, g_at_ov);
    end
    checks++;
    if (order.size() < 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 0) begin
      errors++; $display("FAIL overrun_grant_seq got=%p want prefix '{0,1,2,0}", order);
    end
  endtask

  task automatic test_divisor_clamp();
    int ticks;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, '0, want_done(1), 1'b0, 0);
      checks++;
      if (a_vec !== e_vec) begin
        errors++; $display("FAIL clamp_drain cyc=%0d got=%b want=%b", cyc, a_vec, e_vec);
      end
    end
    checks++;
    if (a_vec[6] !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%b want=1", a_vec[6]); end
    for (int d = 0; d < 2; d++) begin
      cycle(1'b0, '0, 1'b0, 1'b1, d);
      ticks = 0;
      for (int i = 0; i < 10; i++) begin
        cycle(1'b0, '0, 1'b0, 1'b0, 0);
        checks++;
        if (a_vec !== e_vec) begin
          errors++; $display("FAIL clamp_run din=%0d cyc=%0d got=%b want=%b", d, cyc, a_vec, e_vec);
        end
        if (i == 0) begin
          checks++;
          if (a_vec[6] !== 1'b0) begin errors++; $display("FAIL overrun_cleared got=%b want=0", a_vec[6]); end
        end
        ticks += a_vec[9];
      end
      checks++;
      if (ticks != 5) begin errors++; $display("FAIL clamp_ticks din=%0d got=%0d want=5", d, ticks); end
    end
  endtask

  task automatic test_reset_mid_serve();
    int tick_at = -1;
    bit reached = 1'b0;
    cycle(1'b1, '0, 1'b0, 1'b0, 0);
    cycle(1'b0, '0, 1'b0, 1'b1, 16);
    for (int i = 0; i < 100 && !reached; i++) begin
      cycle(1'b0, 4'b0011, (m_cur == 0) && (g_age == 2), 1'b0, 0);
      if (m_cur == 1) reached = 1'b1;
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL reset_mid_reach_v1 got=timeout want=grant v1"); end
    cycle(1'b0, 4'b0011, 1'b0, 1'b0, 0);
    checks++;
    if (a_vec[3:0] !== 4'b0010) begin
      errors++; $display("FAIL reset_mid_v1_grant got=%b want=0010", a_vec[3:0]);
    end
    cycle(1'b1, 4'b0011, 1'b0, 1'b0, 0);
    for (int i = 1; i <= 1100 && tick_at < 0; i++) begin
      cycle(1'b0, 4'b0011, 1'b0, 1'b0, 0);
      if (i == 1) begin
        checks++;
        if (a_vec !== 10'b0) begin
          errors++; $display("FAIL reset_mid_outputs got=%b want=%b", a_vec, 10'b0);
        end
      end
      checks++;
      if (a_vec !== e_vec) begin
        errors++; $display("FAIL reset_mid_run cyc=%0d got=%b want=%b", cyc, a_vec, e_vec);
      end
      if (a_vec[9]) tick_at = i;
    end
    checks++;
    if (tick_at != DEF_DIV) begin
      errors++; $display("FAIL reset_first_tick got=%0d want=%0d", tick_at, DEF_DIV);
    end
  endtask

  task automatic test_random();
    bit [NV-1:0] req = 4'b0101;
    bit          rst, load, done;
    int          din;
    cycle(1'b0, req, 1'b0, 1'b1, 6);
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 499) == 0);
      load = !rst && ($urandom_range(0, 59) == 0);
      din  = $urandom_range(0, 12);
      if ($urandom_range(0, 9) == 0) req = NV'($urandom);
      done = (m_cur >= 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      cycle(rst, req, done, load, din);
      checks++;
      if (a_vec !== e_vec) begin
        errors++; $display("FAIL random cyc=%0d got=%b want=%b", cyc, a_vec, e_vec);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_ticks();
    test_ordered_frame();
    test_overrun();
    test_divisor_clamp();
    test_reset_mid_serve();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
